// File: rtl/otp_ctrl_chk_arb.sv
// otp_ctrl_chk_arb: round-robin arbiter that issues the timer's broadcast check requests to one partition at a time
module otp_ctrl_chk_arb #(
    parameter int NumPart = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumPart-1:0] integ_chk_req_i,
    input  logic [NumPart-1:0] cnsty_chk_req_i,
    output logic [NumPart-1:0] integ_chk_ack_o,
    output logic [NumPart-1:0] cnsty_chk_ack_o,
    output logic [NumPart-1:0] part_integ_chk_req_o,
    output logic [NumPart-1:0] part_cnsty_chk_req_o,
    input  logic [NumPart-1:0] part_integ_chk_ack_i,
    input  logic [NumPart-1:0] part_cnsty_chk_ack_i,
    input  logic [3:0]         escalate_en_i,
    output logic               busy_o,
    output logic               fsm_err_o
);
    localparam int IdxW = (NumPart > 1) ? $clog2(NumPart) : 1;
    localparam logic [3:0] LcTxOff = 4'b1010;

    // Pairwise Hamming distance >= 3 so a single upset lands in an illegal code.
    typedef enum logic [4:0] {
        IdleSt      = 5'b01011,
        IntegWaitSt = 5'b10110,
        CnstyWaitSt = 5'b11101,
        ErrorSt     = 5'b00000
    } state_e;

    state_e             state_q, state_d;
    logic [NumPart-1:0] gnt_q, gnt_d, req_vec, wait_req, wait_ack;
    logic [IdxW-1:0]    rr_q, rr_d, idx_q, idx_d, sel_idx;
    logic               esc, in_integ, in_cnsty, hit;

    assign esc      = escalate_en_i != LcTxOff;
    assign in_integ = state_q == IntegWaitSt;
    assign in_cnsty = state_q == CnstyWaitSt;
    assign req_vec  = (|integ_chk_req_i) ? integ_chk_req_i : cnsty_chk_req_i;
    assign wait_req = in_integ ? integ_chk_req_i : cnsty_chk_req_i;
    assign wait_ack = in_integ ? part_integ_chk_ack_i : part_cnsty_chk_ack_i;
    assign hit      = (in_integ | in_cnsty) & (|(wait_ack & gnt_q)) & ~esc;

    assign integ_chk_ack_o      = (in_integ & hit) ? gnt_q : '0;
    assign cnsty_chk_ack_o      = (in_cnsty & hit) ? gnt_q : '0;
    assign part_integ_chk_req_o = in_integ ? gnt_q : '0;
    assign part_cnsty_chk_req_o = in_cnsty ? gnt_q : '0;
    assign busy_o               = in_integ | in_cnsty;
    assign fsm_err_o            = !(state_q inside {IdleSt, IntegWaitSt, CnstyWaitSt});

    // Scan downwards so the candidate closest to rr_q is assigned last and wins.
    always_comb begin
        sel_idx = '0;
        for (int k = NumPart - 1; k >= 0; k--) begin
            if (req_vec[IdxW'((int'(rr_q) + k) % NumPart)]) sel_idx = IdxW'((int'(rr_q) + k) % NumPart);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        case (state_q)
            IdleSt: begin
                if (|req_vec) begin
                    state_d = (|integ_chk_req_i) ? IntegWaitSt : CnstyWaitSt;
                    gnt_d   = NumPart'(1) << sel_idx;
                    idx_d   = sel_idx;
                end
            end
            IntegWaitSt, CnstyWaitSt: begin
                if (hit) begin
                    state_d = IdleSt;
                    gnt_d   = '0;
                    rr_d    = (idx_q == IdxW'(NumPart - 1)) ? '0 : idx_q + 1'b1;
                end else if (!(|(wait_req & gnt_q))) begin
                    state_d = IdleSt;
                    gnt_d   = '0;
                end
            end
            ErrorSt: gnt_d = '0;
            default: begin
                state_d = ErrorSt;
                gnt_d   = '0;
            end
        endcase
        if (esc) begin
            state_d = ErrorSt;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IdleSt;
            gnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(part_integ_chk_req_o | part_cnsty_chk_req_o));
    a_integ_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(integ_chk_ack_o));
    a_cnsty_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(cnsty_chk_ack_o));
    a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({integ_chk_ack_o, cnsty_chk_ack_o, part_integ_chk_req_o,
                     part_cnsty_chk_req_o, busy_o, fsm_err_o}));
endmodule

// File: tb/tb_otp_ctrl_chk_arb.sv
// tb_otp_ctrl_chk_arb: directed stimulus with a behavioural arbiter model checked every cycle
module tb_otp_ctrl_chk_arb;
    logic       clk_i = 1'b0, rst_ni = 1'b0;
    logic [7:0] integ_chk_req_i = '0, cnsty_chk_req_i = '0;
    logic [7:0] part_integ_chk_ack_i = '0, part_cnsty_chk_ack_i = '0;
    logic [3:0] escalate_en_i = 4'b1010;
    logic [7:0] integ_chk_ack_o, cnsty_chk_ack_o, part_integ_chk_req_o, part_cnsty_chk_req_o;
    logic       busy_o, fsm_err_o;

    int         checks = 0, failures = 0;
    int         pin_seq = 0, pin_done = 0, pin_sel = 0;
    string      pin_name = "";
    logic [7:0] pin_exp = '0;
    int         m_kind = 0;
    logic [2:0] m_idx = '0, m_rr = '0;
    logic       m_err = 1'b0;
    bit         auto_t = 1'b0, auto_p = 1'b0;
    int         cnt = 0;

    always #5 clk_i = ~clk_i;

    otp_ctrl_chk_arb #(.NumPart(8)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .integ_chk_req_i(integ_chk_req_i),
        .cnsty_chk_req_i(cnsty_chk_req_i),
        .integ_chk_ack_o(integ_chk_ack_o),
        .cnsty_chk_ack_o(cnsty_chk_ack_o),
        .part_integ_chk_req_o(part_integ_chk_req_o),
        .part_cnsty_chk_req_o(part_cnsty_chk_req_o),
        .part_integ_chk_ack_i(part_integ_chk_ack_i),
        .part_cnsty_chk_ack_i(part_cnsty_chk_ack_i),
        .escalate_en_i(escalate_en_i),
        .busy_o(busy_o),
        .fsm_err_o(fsm_err_o)
    );

    function void chk(string n, logic [33:0] act, logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    function automatic logic [2:0] pick(logic [7:0] v, logic [2:0] rr);
        for (int k = 0; k < 8; k++) if (v[rr + 3'(k)]) return rr + 3'(k);
        return 3'd0;
    endfunction

    function automatic logic [7:0] pin_val(int s);
        case (s)
            0: return part_integ_chk_req_o;
            1: return part_cnsty_chk_req_o;
            2: return integ_chk_ack_o;
            3: return cnsty_chk_ack_o;
            5: return integ_chk_req_i;
            default: return {6'b0, busy_o, fsm_err_o};
        endcase
    endfunction

    always @(negedge clk_i) begin : cmp
        logic       esc, hit;
        logic [7:0] one, ack_k, req_k;
        if (pin_seq != pin_done) begin
            pin_done = pin_seq;
            chk(pin_name, 34'(pin_val(pin_sel)), 34'(pin_exp));
        end
        if (!rst_ni) begin
            chk("reset_outputs", {integ_chk_ack_o, cnsty_chk_ack_o, part_integ_chk_req_o,
                                  part_cnsty_chk_req_o, busy_o, fsm_err_o}, '0);
            m_kind = 0; m_idx = '0; m_rr = '0; m_err = 1'b0;
        end else begin
            esc   = escalate_en_i != 4'b1010;
            one   = 8'd1 << m_idx;
            ack_k = (m_kind == 1) ? part_integ_chk_ack_i : part_cnsty_chk_ack_i;
            req_k = (m_kind == 1) ? integ_chk_req_i : cnsty_chk_req_i;
            hit   = (m_kind != 0) && !esc && ack_k[m_idx];
            chk("part_integ_req", 34'(part_integ_chk_req_o), 34'((m_kind == 1) ? one : 8'h0));
            chk("part_cnsty_req", 34'(part_cnsty_chk_req_o), 34'((m_kind == 2) ? one : 8'h0));
            chk("integ_ack", 34'(integ_chk_ack_o), 34'((m_kind == 1 && hit) ? one : 8'h0));
            chk("cnsty_ack", 34'(cnsty_chk_ack_o), 34'((m_kind == 2 && hit) ? one : 8'h0));
            chk("busy", 34'(busy_o), 34'(m_kind != 0));
            chk("fsm_err", 34'(fsm_err_o), 34'(m_err));
            if (esc) begin
                m_err = 1'b1; m_kind = 0;
            end else if (!m_err) begin
                if (m_kind == 0) begin
                    if (|integ_chk_req_i) begin m_kind = 1; m_idx = pick(integ_chk_req_i, m_rr); end
                    else if (|cnsty_chk_req_i) begin m_kind = 2; m_idx = pick(cnsty_chk_req_i, m_rr); end
                end else if (hit) begin
                    m_kind = 0; m_rr = m_idx + 3'd1;
                end else if (!req_k[m_idx]) m_kind = 0;
            end
        end
    end

    task automatic pin(string n, int s, logic [7:0] e);
        pin_name = n; pin_sel = s; pin_exp = e; pin_seq++;
    endtask

    // One cycle of the timer (clears acked bits) and partitions (ack on 3rd request cycle).
    task automatic tick();
        logic [7:0] ia, ca;
        @(negedge clk_i);
        ia = integ_chk_ack_o;
        ca = cnsty_chk_ack_o;
        @(posedge clk_i);
        #1;
        if (auto_t) begin
            integ_chk_req_i &= ~ia;
            cnsty_chk_req_i &= ~ca;
        end
        if (auto_p) begin
            cnt = (|(part_integ_chk_req_o | part_cnsty_chk_req_o)) ? cnt + 1 : 0;
            part_integ_chk_ack_i = (cnt == 3) ? part_integ_chk_req_o : 8'h0;
            part_cnsty_chk_ack_i = (cnt == 3) ? part_cnsty_chk_req_o : 8'h0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        pin("idle_after_reset", 4, 8'h00); tick();
        auto_t = 1'b1; auto_p = 1'b1;
        integ_chk_req_i = 8'hFF; tick();
        pin("s1_first_grant", 0, 8'h01);
        for (int i = 0; i < 100 && integ_chk_req_i != 8'h00; i++) tick();
        pin("s1_all_acked", 5, 8'h00); tick();
        integ_chk_req_i = 8'h10;
        for (int i = 0; i < 20 && integ_chk_req_i != 8'h00; i++) tick();
        cnsty_chk_req_i = 8'h21; tick();
        pin("s2_first_p5", 1, 8'h20); tick(); tick();
        pin("s2_ack_p5", 3, 8'h20); tick(); tick();
        pin("s2_then_p0", 1, 8'h01);
        for (int i = 0; i < 20 && cnsty_chk_req_i != 8'h00; i++) tick();
        integ_chk_req_i = 8'h04; cnsty_chk_req_i = 8'h02; tick();
        pin("s3_integ_first", 0, 8'h04); repeat (4) tick();
        pin("s3_cnsty_second", 1, 8'h02);
        for (int i = 0; i < 20 && cnsty_chk_req_i != 8'h00; i++) tick();
        auto_p = 1'b0;
        integ_chk_req_i = 8'h08; tick();
        pin("s4_grant3", 0, 8'h08); tick();
        part_integ_chk_ack_i = 8'h10; part_cnsty_chk_ack_i = 8'h08;
        pin("s4_wrong_bit", 2, 8'h00); tick();
        part_integ_chk_ack_i = 8'h08; part_cnsty_chk_ack_i = 8'h00;
        pin("s4_right_bit", 2, 8'h08); tick();
        part_integ_chk_ack_i = 8'h00;
        pin("s4_idle", 4, 8'h00); tick();
        integ_chk_req_i = 8'h04; tick();
        pin("s5_grant2", 0, 8'h04); tick();
        integ_chk_req_i = 8'h00;
        pin("s5_still_req", 0, 8'h04); tick();
        pin("s5_withdrawn", 0, 8'h00); tick();
        integ_chk_req_i = 8'hFF; tick();
        pin("s5_rr_kept", 0, 8'h10); tick();
        escalate_en_i = 4'b0101; part_integ_chk_ack_i = 8'h10;
        pin("esc_ack_gated", 2, 8'h00); tick();
        part_integ_chk_ack_i = 8'h00;
        pin("esc_err", 4, 8'h01); tick();
        escalate_en_i = 4'b1010;
        pin("esc_no_req", 0, 8'h00); tick(); tick();
        pin("esc_sticky", 4, 8'h01); tick();
        rst_ni = 1'b0;
        pin("rst_clear", 4, 8'h00); tick();
        rst_ni = 1'b1; tick();
        pin("post_rst_grant", 0, 8'h01); tick();
        #2 rst_ni = 1'b0;
        pin("midcheck_rst", 0, 8'h00); tick();
        integ_chk_req_i = 8'h00; rst_ni = 1'b1;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
